// File: rtl/arp_tx.sv
`default_nettype none
// ============================================================================
// Module   : arp_tx
// Purpose  : Builds and streams 46-byte ARP request/reply payloads to the MAC.
// Revision : 1.0 - initial release
// ============================================================================
module arp_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] local_mac_addr,
  input  logic [31:0] local_ip_addr,
  input  logic [31:0] dest_ip_addr,
  input  logic        arp_request_req,
  output logic        arp_request_ack,
  input  logic        arp_reply_req,
  output logic        arp_reply_ack,
  input  logic [31:0] arp_rec_source_ip_addr,
  input  logic [47:0] arp_rec_source_mac_addr,
  output logic        arp_tx_req,
  input  logic        mac_tx_ack,
  output logic        arp_tx_valid,
  output logic [7:0]  arp_tx_data,
  output logic        arp_tx_end,
  output logic [47:0] arp_dest_mac_addr
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_TX_REQ  = 2'd1;
  localparam logic [1:0]  S_TX_DATA = 2'd2;
  localparam logic [1:0]  S_TX_END  = 2'd3;
  localparam logic [7:0]  LAST_BYTE = 8'd45;
  localparam logic [7:0]  HDR_BYTES = 8'd28;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  logic [1:0]   state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         is_reply_q, is_reply_d;
  logic [47:0]  src_mac_q, src_mac_d;
  logic [31:0]  src_ip_q, src_ip_d;
  logic [47:0]  tgt_mac_q, tgt_mac_d;
  logic [31:0]  tgt_ip_q, tgt_ip_d;
  logic [47:0]  dest_mac_q, dest_mac_d;
  logic         req_ack_q, req_ack_d;
  logic         rep_ack_q, rep_ack_d;
  logic         start_w;
  logic [223:0] hdr_w;
  logic [4:0]   byte_sel_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (arp_reply_req || arp_request_req) state_d = S_TX_REQ;
      S_TX_REQ:  if (mac_tx_ack) state_d = S_TX_DATA;
      S_TX_DATA: if (cnt_q == LAST_BYTE) state_d = S_TX_END;
      S_TX_END:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Frame fields are captured only when leaving IDLE; reply has priority.
  always_comb begin
    start_w    = (state_q == S_IDLE) && (arp_reply_req || arp_request_req);
    is_reply_d = is_reply_q;
    src_mac_d  = src_mac_q;
    src_ip_d   = src_ip_q;
    tgt_mac_d  = tgt_mac_q;
    tgt_ip_d   = tgt_ip_q;
    dest_mac_d = dest_mac_q;
    req_ack_d  = start_w && !arp_reply_req;
    rep_ack_d  = start_w && arp_reply_req;
    cnt_d      = (state_q == S_TX_DATA) ? cnt_q + 8'd1 : 8'd0;
    if (start_w) begin
      is_reply_d = arp_reply_req;
      src_mac_d  = local_mac_addr;
      src_ip_d   = local_ip_addr;
      tgt_mac_d  = arp_reply_req ? arp_rec_source_mac_addr : 48'd0;
      tgt_ip_d   = arp_reply_req ? arp_rec_source_ip_addr : dest_ip_addr;
      dest_mac_d = arp_reply_req ? arp_rec_source_mac_addr : BCAST_MAC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 8'd0;
      is_reply_q <= 1'b0;
      src_mac_q  <= 48'd0;
      src_ip_q   <= 32'd0;
      tgt_mac_q  <= 48'd0;
      tgt_ip_q   <= 32'd0;
      dest_mac_q <= 48'd0;
      req_ack_q  <= 1'b0;
      rep_ack_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      is_reply_q <= is_reply_d;
      src_mac_q  <= src_mac_d;
      src_ip_q   <= src_ip_d;
      tgt_mac_q  <= tgt_mac_d;
      tgt_ip_q   <= tgt_ip_d;
      dest_mac_q <= dest_mac_d;
      req_ack_q  <= req_ack_d;
      rep_ack_q  <= rep_ack_d;
    end
  end

  always_comb begin
    arp_tx_req        = (state_q == S_TX_REQ);
    arp_tx_valid      = (state_q == S_TX_DATA);
    arp_tx_end        = (state_q == S_TX_END);
    arp_request_ack   = req_ack_q;
    arp_reply_ack     = rep_ack_q;
    arp_dest_mac_addr = dest_mac_q;
    hdr_w = {16'h0001, 16'h0800, 8'h06, 8'h04,
             {14'd0, is_reply_q, ~is_reply_q},
             src_mac_q, src_ip_q, tgt_mac_q, tgt_ip_q};
    // Byte 0 sits in the top octet of the 28-byte header vector.
    byte_sel_w  = 5'd27 - cnt_q[4:0];
    arp_tx_data = 8'h00;
    if (arp_tx_valid && (cnt_q < HDR_BYTES))
      arp_tx_data = hdr_w[{byte_sel_w, 3'b000} +: 8];
  end

endmodule
`default_nettype wire

// File: doc/arp_tx.md
ARP_TX -- requirements
Module: arp_tx

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state advances on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port local_mac_addr, input, 48, sender MAC placed in every frame.
REQ-004 SHALL have port local_ip_addr, input, 32, sender IP placed in every frame.
REQ-005 SHALL have port dest_ip_addr, input, 32, target IP for ARP requests.
REQ-006 SHALL have port arp_request_req, input, 1, level; upper layer asks for ARP request; held until arp_request_ack.
REQ-007 SHALL have port arp_request_ack, output, 1, one-cycle pulse when a request is accepted.
REQ-008 SHALL have port arp_reply_req, input, 1, level from ARP receiver; held until arp_reply_ack.
REQ-009 SHALL have port arp_reply_ack, output, 1, one-cycle pulse when a reply is accepted.
REQ-010 SHALL have port arp_rec_source_ip_addr, input, 32, requester IP; becomes target IP of the reply.
REQ-011 SHALL have port arp_rec_source_mac_addr, input, 48, requester MAC; becomes target MAC of the reply.
REQ-012 SHALL have port arp_tx_req, output, 1, level request to the MAC for the transmit path.
REQ-013 SHALL have port mac_tx_ack, input, 1, MAC grant; sampled only while arp_tx_req is high.
REQ-014 SHALL have port arp_tx_valid, output, 1, high while arp_tx_data carries a payload byte.
REQ-015 SHALL have port arp_tx_data, output, 8, ARP payload byte.
REQ-016 SHALL have port arp_tx_end, output, 1, one-cycle pulse after the last byte.
REQ-017 SHALL have port arp_dest_mac_addr, output, 48, Ethernet destination for the MAC header.

Function
REQ-018 SHALL implement FSM IDLE -> TX_REQ -> TX_DATA -> TX_END -> IDLE.
REQ-019 IDLE: arp_reply_req high -> TX_REQ as reply. Else arp_request_req high -> TX_REQ as request. Else stay.
REQ-020 Reply SHALL win when both requests are high in the same cycle; the request stays pending and is served after TX_END.
REQ-021 On leaving IDLE, SHALL latch op, target MAC, target IP and arp_dest_mac_addr, and pulse the matching ack for exactly 1 cycle; later input changes SHALL NOT alter the frame in flight.
REQ-022 TX_REQ SHALL assert arp_tx_req and wait indefinitely for mac_tx_ack; on ack, drop arp_tx_req and enter TX_DATA next cycle.
REQ-023 TX_DATA SHALL hold arp_tx_valid high for exactly 46 consecutive cycles, byte k (0..45) on the k-th valid cycle; 8-bit counter cleared outside TX_DATA.
REQ-024 Byte map: 0-1 = 0x0001; 2-3 = 0x0800; 4 = 0x06; 5 = 0x04; 6-7 = op; 8-13 = local_mac_addr; 14-17 = local_ip_addr; 18-23 = target MAC; 24-27 = target IP; 28-45 = 0x00 pad. All fields MSB first.
REQ-025 Request: op 0x0001, target MAC 0, target IP dest_ip_addr, arp_dest_mac_addr 48'hFFFFFFFFFFFF.
REQ-026 Reply: op 0x0002, target MAC/IP = latched arp_rec_source_mac_addr/ip, arp_dest_mac_addr = latched arp_rec_source_mac_addr.
REQ-027 local_mac_addr/local_ip_addr SHALL be latched with the other fields.
REQ-028 arp_tx_end SHALL pulse in TX_END, the cycle after the last valid byte; FSM returns to IDLE the next cycle.
REQ-029 arp_tx_data SHALL be 0x00 whenever arp_tx_valid is low.
REQ-030 mac_tx_ack outside TX_REQ SHALL be ignored.

Reset
REQ-031 rst_n low SHALL force IDLE, counter 0, all outputs 0 (arp_dest_mac_addr 0) immediately, including mid-frame.
REQ-032 After reset release, a frame interrupted by reset SHALL NOT resume; a still-held req SHALL start a fresh frame.

Verification
REQ-033 Request, local 00:0A:35:01:FE:C0/192.168.0.2, dest 192.168.0.3, ack 3 cycles later -> 46 bytes: 00 01 08 00 06 04 00 01 00 0A 35 01 FE C0 C0 A8 00 02, six 00, C0 A8 00 03, eighteen 00; dest MAC all-FF; arp_tx_end 1 cycle after the last byte.
REQ-034 Reply to 192.168.0.3 / 11:22:33:44:55:66 -> op bytes 00 02, bytes 18-23 = 11 22 33 44 55 66, arp_dest_mac_addr 0x112233445566, arp_reply_ack 1 cycle wide.
REQ-035 Both reqs high on the same cycle -> reply frame first, then request frame; each ack pulses once.
REQ-036 mac_tx_ack withheld 1000 cycles -> arp_tx_req held, no valid; source inputs changed after the ack -> frame unchanged.
REQ-037 rst_n low at byte 20 -> all outputs 0 same cycle; after release with arp_request_req held -> full 46-byte frame from byte 0.
